fp_mul_seq: RTL and testbench

FP_MUL_SEQ -- requirements
Module: fp_mul_seq

---
 rtl/fp_mul_seq_if.sv | 29 ++
 rtl/fp_mul_seq.sv | 256 +++++++++++++++++++++++++
 tb/tb_fp_mul_seq.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_mul_seq_if.sv
// Handshake and data bundle for the sequential floating-point multiplier.
// The master side presents operands and consumes results; the slave side
// is the multiplier itself.
interface fp_mul_seq_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic [1:0]   rnd_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] product;
  logic [3:0]   flags;

  modport master (
    output in_valid, operand_a, operand_b, rnd_mode, out_ready,
    input  in_ready, out_valid, product, flags
  );

  modport slave (
    input  in_valid, operand_a, operand_b, rnd_mode, out_ready,
    output in_ready, out_valid, product, flags
  );
endinterface

// File: rtl/fp_mul_seq.sv
// Sequential IEEE-754-style multiplier, one operation in flight.
// Operation walks IDLE -> DECODE -> MULT -> ROUND -> HOLD; the result
// word and flags {NV, OF, UF, NX} are held until the consumer takes them.
module fp_mul_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input logic         clk,
  input logic         reset,
  fp_mul_seq_if.slave bus
);
  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int EW  = EXP_W + 2;           // signed internal exponent width
  localparam int SW  = MAN_W + 1;           // significand incl. hidden bit
  localparam int PW  = 2 * SW;              // exact significand product
  localparam int LZW = $clog2(MAN_W + 1);
  localparam int SHW = $clog2(PW + 1);

  localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] ONE  = EW'(1);
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);
  localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE, S_DECODE, S_MULT, S_ROUND, S_HOLD
  } state_t;

  // Decoded operand: class bits plus a normalised significand and a
  // biased exponent that may go below 1 for subnormal inputs.
  typedef struct packed {
    logic                 sign;
    logic                 zero;
    logic                 inf;
    logic                 qnan;
    logic                 snan;
    logic signed [EW-1:0] exp;
    logic [SW-1:0]        sig;
  } opnd_t;

  // Classify one word and normalise subnormals with a leading-zero count.
  function automatic opnd_t decode(input logic [W-1:0] x);
    opnd_t            d;
    logic [EXP_W-1:0] ef;
    logic [MAN_W-1:0] ff;
    logic [LZW-1:0]   lz;
    d  = '0;
    ef = x[W-2 -: EXP_W];
    ff = x[MAN_W-1:0];
    lz = LZW'(MAN_W);
    for (int i = 0; i < MAN_W; i++) begin
      if (ff[i]) lz = LZW'(MAN_W - 1 - i);
    end
    d.sign = x[W-1];
    if (ef == '1) begin
      if (ff == '0)          d.inf  = 1'b1;
      else if (ff[MAN_W-1])  d.qnan = 1'b1;
      else                   d.snan = 1'b1;
    end else if (ef == '0) begin
      if (ff == '0) begin
        d.zero = 1'b1;
      end else begin
        // Leading one moves to the hidden-bit position; exponent drops by lz.
        d.sig = {ff, 1'b0} << lz;
        d.exp = -$signed(EW'(lz));
      end
    end else begin
      d.sig = {1'b1, ff};
      d.exp = $signed({2'b00, ef});
    end
    return d;
  endfunction

  state_t state_q, next_state;
  logic   accept;

  logic [W-1:0]         op_a_q, op_b_q;
  logic [1:0]           rnd_q;
  opnd_t                dec_a_q, dec_b_q;
  logic [PW-1:0]        prod_q;
  logic signed [EW-1:0] exp_q;
  logic                 sign_q;
  logic                 spec_q;
  logic [W-1:0]         spec_word_q;
  logic [3:0]           spec_flags_q;
  logic [W-1:0]         product_q;
  logic [3:0]           flags_q;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block ordering.
    if (reset) state_q <= S_IDLE;
    else       state_q <= next_state;
  end

  // Next-state and handshake outputs.
  always_comb begin
    // NOTE: every output of this block is given a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    next_state    = state_q;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    accept        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        bus.in_ready = 1'b1;
        accept       = bus.in_valid;
        if (bus.in_valid) next_state = S_DECODE;
      end
      S_DECODE: next_state = S_MULT;
      S_MULT:   next_state = S_ROUND;
      S_ROUND:  next_state = S_HOLD;
      S_HOLD: begin
        bus.out_valid = 1'b1;
        if (bus.out_ready) next_state = S_IDLE;
      end
      default:  next_state = S_IDLE;
    endcase
  end

  // Special-case result selection, evaluated from the decoded operands.
  logic         nan_in, zero_inf;
  logic         spec;
  logic [W-1:0] spec_word;
  logic [3:0]   spec_flags;

  always_comb begin
    spec       = 1'b0;
    spec_word  = '0;
    spec_flags = '0;
    nan_in     = dec_a_q.qnan | dec_a_q.snan | dec_b_q.qnan | dec_b_q.snan;
    zero_inf   = (dec_a_q.zero & dec_b_q.inf) | (dec_a_q.inf & dec_b_q.zero);
    if (nan_in || zero_inf) begin
      spec       = 1'b1;
      spec_word  = QNAN;
      spec_flags = {dec_a_q.snan | dec_b_q.snan | zero_inf, 3'b000};
    end else if (dec_a_q.inf || dec_b_q.inf) begin
      spec      = 1'b1;
      spec_word = {dec_a_q.sign ^ dec_b_q.sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (dec_a_q.zero || dec_b_q.zero) begin
      spec      = 1'b1;
      spec_word = {dec_a_q.sign ^ dec_b_q.sign, {(W-1){1'b0}}};
    end
  end

  // Datapath pipeline: capture, decode, multiply, each enabled by its state.
  // NOTE: these registers carry no reset; the FSM never lets a stale value
  // reach the outputs, so only the visible state and result are reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      op_a_q <= bus.operand_a;
      op_b_q <= bus.operand_b;
      rnd_q  <= bus.rnd_mode;
    end
    if (state_q == S_DECODE) begin
      dec_a_q <= decode(op_a_q);
      dec_b_q <= decode(op_b_q);
    end
    if (state_q == S_MULT) begin
      prod_q       <= PW'(dec_a_q.sig) * PW'(dec_b_q.sig);
      exp_q        <= dec_a_q.exp + dec_b_q.exp - BIAS;
      sign_q       <= dec_a_q.sign ^ dec_b_q.sign;
      spec_q       <= spec;
      spec_word_q  <= spec_word;
      spec_flags_q <= spec_flags;
    end
  end

  // Rounding stage signals.
  logic                 top, tiny, lost, guard, sticky, inc, hidden;
  logic                 of, nx, uf, to_inf;
  logic [PW-1:0]        norm, shifted;
  logic signed [EW-1:0] e_n, e_r, e_f;
  int                   sh_int;
  logic [SHW-1:0]       sh;
  logic [SW-1:0]        sig;
  logic [SW:0]          rsig;
  logic [MAN_W-1:0]     frac;
  logic [W-1:0]         round_word;
  logic [3:0]           round_flags;

  // Normalise, denormalise into the subnormal range, round and pack.
  always_comb begin
    inc         = 1'b0;
    sh          = '0;
    to_inf      = 1'b0;
    round_word  = '0;
    round_flags = '0;

    top  = prod_q[PW-1];
    norm = top ? prod_q : {prod_q[PW-2:0], 1'b0};
    e_n  = exp_q + EW'(top);
    tiny = e_n < ONE;

    // Shift amount saturates at PW: beyond that everything is sticky.
    sh_int = 1 - int'(e_n);
    if (tiny) sh = (sh_int > PW) ? SHW'(PW) : SHW'(sh_int);
    shifted = norm >> sh;
    lost    = (shifted << sh) != norm;

    sig    = shifted[PW-1 -: SW];
    guard  = shifted[MAN_W];
    sticky = (|shifted[MAN_W-1:0]) | lost;
    e_r    = tiny ? ONE : e_n;

    unique case (rnd_q)
      2'b00: inc = guard & (sticky | sig[0]);
      2'b01: inc = 1'b0;
      2'b10: inc = sign_q & (guard | sticky);
      2'b11: inc = ~sign_q & (guard | sticky);
    endcase

    rsig = {1'b0, sig} + {{SW{1'b0}}, inc};
    if (rsig[SW]) begin
      e_f    = e_r + ONE;
      frac   = '0;
      hidden = 1'b1;
    end else begin
      e_f    = e_r;
      frac   = rsig[MAN_W-1:0];
      hidden = rsig[MAN_W];
    end

    of = e_f >= EMAX;
    nx = guard | sticky | of;
    uf = tiny & (guard | sticky);

    if (spec_q) begin
      round_word  = spec_word_q;
      round_flags = spec_flags_q;
    end else if (of) begin
      to_inf = (rnd_q == 2'b00) | ((rnd_q == 2'b10) & sign_q) |
               ((rnd_q == 2'b11) & ~sign_q);
      round_word = to_inf ? {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                          : {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
      round_flags = 4'b0101;
    end else begin
      round_word  = {sign_q, hidden ? e_f[EXP_W-1:0] : {EXP_W{1'b0}}, frac};
      round_flags = {1'b0, 1'b0, uf, nx};
    end
  end

  // Result register, loaded as the operation enters HOLD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      product_q <= '0;
      flags_q   <= '0;
    end else if (state_q == S_ROUND) begin
      product_q <= round_word;
      flags_q   <= round_flags;
    end
  end

  assign bus.product = product_q;
  assign bus.flags   = flags_q;
endmodule

// File: tb/tb_fp_mul_seq.sv
// Self-checking bench for fp_mul_seq: directed cases for binary32 and
// binary16 instances plus randomized operations against an exact-arithmetic
// reference model.
module tb_fp_mul_seq;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  fp_mul_seq_if #(.EXP_W(8), .MAN_W(23)) bus32 ();
  fp_mul_seq_if #(.EXP_W(5), .MAN_W(10)) bus16 ();

  fp_mul_seq #(.EXP_W(8), .MAN_W(23)) dut32 (.clk(clk), .reset(reset), .bus(bus32));
  fp_mul_seq #(.EXP_W(5), .MAN_W(10)) dut16 (.clk(clk), .reset(reset), .bus(bus16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] pack(input bit s, input int ew, input int mw,
                                       input int field, input longint unsigned fr);
    longint unsigned v;
    v = (longint'(s) << (ew + mw)) | (longint'(field) << mw) | fr;
    return v[31:0];
  endfunction

  // Exact product M*2^X rounded to the quantum of the target format.
  function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                  input int ew, input int mw, input logic [1:0] rm,
                                  output logic [31:0] res, output logic [3:0] fl);
    int bias, emaxf, emin_q, ea, eb, xa, xb, x, msb, lead, q, d, field;
    longint unsigned fa, fb, ma, mb, p, r, rem, half, fr;
    bit sa, sb, s, a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
    bit inexact, above, tie, up, tiny, zi, to_inf;
    bias   = (1 << (ew - 1)) - 1;
    emaxf  = (1 << ew) - 1;
    emin_q = 1 - bias - mw;
    sa = a[ew + mw];
    sb = b[ew + mw];
    s  = sa ^ sb;
    ea = int'((a >> mw) & emaxf);
    eb = int'((b >> mw) & emaxf);
    fa = longint'(a) & ((64'd1 << mw) - 1);
    fb = longint'(b) & ((64'd1 << mw) - 1);
    a_nan  = (ea == emaxf) && (fa != 0);
    b_nan  = (eb == emaxf) && (fb != 0);
    a_snan = a_nan && (((fa >> (mw - 1)) & 1) == 0);
    b_snan = b_nan && (((fb >> (mw - 1)) & 1) == 0);
    a_inf  = (ea == emaxf) && (fa == 0);
    b_inf  = (eb == emaxf) && (fb == 0);
    a_zero = (ea == 0) && (fa == 0);
    b_zero = (eb == 0) && (fb == 0);
    zi = (a_zero && b_inf) || (a_inf && b_zero);
    if (a_nan || b_nan || zi) begin
      res = pack(1'b0, ew, mw, emaxf, 64'd1 << (mw - 1));
      fl  = {a_snan || b_snan || zi, 3'b000};
      return;
    end
    if (a_inf || b_inf) begin
      res = pack(s, ew, mw, emaxf, 0);
      fl  = 4'b0000;
      return;
    end
    if (a_zero || b_zero) begin
      res = pack(s, ew, mw, 0, 0);
      fl  = 4'b0000;
      return;
    end
    ma = (ea == 0) ? fa : (fa | (64'd1 << mw));
    mb = (eb == 0) ? fb : (fb | (64'd1 << mw));
    xa = ((ea == 0) ? 1 : ea) - bias - mw;
    xb = ((eb == 0) ? 1 : eb) - bias - mw;
    p  = ma * mb;
    x  = xa + xb;
    msb = 0;
    for (int i = 0; i < 64; i++) if (p[i]) msb = i;
    lead = msb + x;
    tiny = lead < (1 - bias);
    q = (lead - mw > emin_q) ? (lead - mw) : emin_q;
    d = q - x;
    above = 1'b0;
    tie   = 1'b0;
    if (d >= 64) begin
      r   = 0;
      rem = p;
    end else if (d == 0) begin
      r   = p;
      rem = 0;
    end else begin
      r     = p >> d;
      rem   = p - (r << d);
      half  = 64'd1 << (d - 1);
      above = rem > half;
      tie   = rem == half;
    end
    inexact = rem != 0;
    case (rm)
      2'b00:   up = above || (tie && r[0]);
      2'b01:   up = 1'b0;
      2'b10:   up = s && inexact;
      default: up = !s && inexact;
    endcase
    r = r + longint'(up);
    if (r == (64'd1 << (mw + 1))) begin
      r = r >> 1;
      q++;
    end
    if (r >= (64'd1 << mw)) begin
      field = q + mw + bias;
      fr    = r - (64'd1 << mw);
    end else begin
      field = 0;
      fr    = r;
    end
    if (field >= emaxf) begin
      to_inf = (rm == 2'b00) || (rm == 2'b10 && s) || (rm == 2'b11 && !s);
      res = to_inf ? pack(s, ew, mw, emaxf, 0)
                   : pack(s, ew, mw, emaxf - 1, (64'd1 << mw) - 1);
      fl  = 4'b0101;
    end else begin
      res = pack(s, ew, mw, field, fr);
      fl  = {2'b00, tiny && inexact, inexact};
    end
  endfunction

  function automatic logic [31:0] rand32();
    logic [7:0]  e;
    logic [22:0] f;
    case ($urandom_range(0, 9))
      0:       e = 8'd0;
      1:       e = 8'hFF;
      2:       e = 8'($urandom_range(1, 20));
      3:       e = 8'($urandom_range(235, 254));
      4:       e = 8'($urandom_range(0, 255));
      default: e = 8'($urandom_range(64, 190));
    endcase
    f = 23'($urandom);
    if ($urandom_range(0, 7) == 0) f = '0;
    return {1'($urandom), e, f};
  endfunction

  // Present one operation, scramble inputs after accept, wait for out_valid.
  // Returns at the falling edge where out_valid is first seen.
  task automatic run_op(input bit half, input logic [31:0] a, input logic [31:0] b,
                        input logic [1:0] rm, input string tag,
                        output logic [31:0] prod, output logic [3:0] fl, output int lat);
    int n;
    bit rdy, ov;
    prod = '0;
    fl   = '0;
    lat  = 0;
    n    = 0;
    rdy  = half ? bus16.in_ready : bus32.in_ready;
    while (!rdy && n < 20) begin
      @(negedge clk);
      n++;
      rdy = half ? bus16.in_ready : bus32.in_ready;
    end
    if (!rdy) begin
      check({tag, " in_ready"}, 64'(rdy), 64'd1);
      return;
    end
    if (half) begin
      bus16.operand_a = a[15:0];
      bus16.operand_b = b[15:0];
      bus16.rnd_mode  = rm;
      bus16.in_valid  = 1'b1;
    end else begin
      bus32.operand_a = a;
      bus32.operand_b = b;
      bus32.rnd_mode  = rm;
      bus32.in_valid  = 1'b1;
    end
    @(posedge clk);
    #1;
    bus16.in_valid  = 1'b0;
    bus32.in_valid  = 1'b0;
    bus16.operand_a = 16'($urandom);
    bus16.operand_b = 16'($urandom);
    bus16.rnd_mode  = 2'($urandom);
    bus32.operand_a = $urandom;
    bus32.operand_b = $urandom;
    bus32.rnd_mode  = 2'($urandom);
    do begin
      @(negedge clk);
      lat++;
      ov = half ? bus16.out_valid : bus32.out_valid;
    end while (!ov && lat < 20);
    prod = half ? {16'h0, bus16.product} : bus32.product;
    fl   = half ? bus16.flags : bus32.flags;
  endtask

  // out_valid is expected in the 4th cycle after the accepting edge.
  task automatic expect_op(input bit half, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] rm, input string tag,
                           input logic [31:0] exp_p, input logic [3:0] exp_f);
    logic [31:0] p;
    logic [3:0]  f;
    int          lat;
    run_op(half, a, b, rm, tag, p, f, lat);
    check({tag, " latency"}, 64'(lat), 64'd4);
    check({tag, " product"}, 64'(p), 64'(exp_p));
    check({tag, " flags"}, 64'(f), 64'(exp_f));
  endtask

  task automatic random_op(input bit half, input int idx);
    logic [31:0] a, b, rp;
    logic [3:0]  rf;
    logic [1:0]  rm;
    if (half) begin
      a = {16'h0, 16'($urandom)};
      b = {16'h0, 16'($urandom)};
      ref_mul(a, b, 5, 10, rm, rp, rf);
    end else begin
      a = rand32();
      b = rand32();
    end
    rm = 2'($urandom);
    if (half) ref_mul(a, b, 5, 10, rm, rp, rf);
    else      ref_mul(a, b, 8, 23, rm, rp, rf);
    expect_op(half, a, b, rm, $sformatf("rand%0d_%0d", half, idx), rp, rf);
  endtask

  // Hard stop if anything wedges.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] p;
    logic [3:0]  f;
    int          lat;
    bit          seen;
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus32.in_valid = 1'b0; bus32.out_ready = 1'b1;
    bus32.operand_a = '0;  bus32.operand_b = '0; bus32.rnd_mode = 2'b00;
    bus16.in_valid = 1'b0; bus16.out_ready = 1'b1;
    bus16.operand_a = '0;  bus16.operand_b = '0; bus16.rnd_mode = 2'b00;

    // Reset state.
    #12;
    check("reset in_ready", 64'(bus32.in_ready), 64'd1);
    check("reset out_valid", 64'(bus32.out_valid), 64'd0);
    check("reset product", 64'(bus32.product), 64'd0);
    check("reset flags", 64'(bus32.flags), 64'd0);
    @(negedge clk);
    reset = 1'b0;

    // Directed binary32 cases.
    expect_op(0, 32'h3FC00000, 32'h40000000, 2'b00, "1.5x2", 32'h40400000, 4'b0000);
    expect_op(0, 32'h00000000, 32'hFF800000, 2'b00, "0xinf", 32'h7FC00000, 4'b1000);
    expect_op(0, 32'h7FA00000, 32'h3F800000, 2'b00, "snan", 32'h7FC00000, 4'b1000);
    expect_op(0, 32'h7FC00000, 32'h3F800000, 2'b00, "qnan", 32'h7FC00000, 4'b0000);
    expect_op(0, 32'h7F7FFFFF, 32'h40000000, 2'b00, "ovf_rne", 32'h7F800000, 4'b0101);
    expect_op(0, 32'h7F7FFFFF, 32'h40000000, 2'b01, "ovf_rtz", 32'h7F7FFFFF, 4'b0101);
    expect_op(0, 32'hFF7FFFFF, 32'h40000000, 2'b11, "ovf_rup_neg", 32'hFF7FFFFF, 4'b0101);
    expect_op(0, 32'hFF7FFFFF, 32'h40000000, 2'b10, "ovf_rdn_neg", 32'hFF800000, 4'b0101);
    expect_op(0, 32'h00800000, 32'h3F000000, 2'b00, "minnorm_half", 32'h00400000, 4'b0000);
    expect_op(0, 32'h00000001, 32'h3F000000, 2'b00, "tie_to_zero", 32'h00000000, 4'b0011);
    expect_op(0, 32'h80000001, 32'h3F000000, 2'b10, "rdn_sub", 32'h80000001, 4'b0011);
    expect_op(0, 32'h807FFFFF, 32'h3F800001, 2'b00, "sub_to_min", 32'h80800000, 4'b0011);
    expect_op(0, 32'h80000000, 32'h7F800000, 2'b00, "negzero_inf", 32'h7FC00000, 4'b1000);
    expect_op(0, 32'hC0000000, 32'h7F800000, 2'b00, "neg_inf", 32'hFF800000, 4'b0000);

    // Directed binary16 cases.
    expect_op(1, 32'h3C00, 32'h3C00, 2'b00, "h_one", 32'h3C00, 4'b0000);
    expect_op(1, 32'h7BFF, 32'h4000, 2'b00, "h_ovf", 32'h7C00, 4'b0101);

    // Result held while out_ready is low.
    bus32.out_ready = 1'b0;
    run_op(0, 32'h3FC00000, 32'h40000000, 2'b00, "hold", p, f, lat);
    check("hold latency", 64'(lat), 64'd4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("hold%0d product", i), 64'(bus32.product), 64'h40400000);
      check($sformatf("hold%0d in_ready", i), 64'(bus32.in_ready), 64'd0);
      check($sformatf("hold%0d out_valid", i), 64'(bus32.out_valid), 64'd1);
    end
    bus32.out_ready = 1'b1;
    @(negedge clk);
    check("release out_valid", 64'(bus32.out_valid), 64'd0);
    check("release in_ready", 64'(bus32.in_ready), 64'd1);

    // Reset while the operation is in MULT.
    bus32.operand_a = 32'h3FC00000;
    bus32.operand_b = 32'h40000000;
    bus32.rnd_mode  = 2'b00;
    bus32.in_valid  = 1'b1;
    @(posedge clk);
    #1 bus32.in_valid = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("midreset in_ready", 64'(bus32.in_ready), 64'd1);
    check("midreset out_valid", 64'(bus32.out_valid), 64'd0);
    check("midreset product", 64'(bus32.product), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus32.out_valid) seen = 1'b1;
    end
    check("aborted out_valid", 64'(seen), 64'd0);
    expect_op(0, 32'h40400000, 32'hC0000000, 2'b00, "after_reset", 32'hC0C00000, 4'b0000);

    // Randomized operations against the reference model.
    for (int i = 0; i < 300; i++) random_op(0, i);
    for (int i = 0; i < 60; i++) random_op(1, i);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
